// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between fetch (I) and load/store (D) ports,
// sequencing each grant through IDLE -> ACCESS -> RESP on one shared memory.
module mem_arbiter #(
  parameter int BUS_WIDTH = 32,
  parameter bit I_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req,
  input  logic [BUS_WIDTH-1:0] i_addr,
  output logic                 i_ack,
  output logic [BUS_WIDTH-1:0] i_rdata,
  output logic                 i_err,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [BUS_WIDTH-1:0] d_addr,
  input  logic [BUS_WIDTH-1:0] d_wdata,
  input  logic [1:0]           d_size,
  input  logic                 d_sign,
  output logic                 d_ack,
  output logic [BUS_WIDTH-1:0] d_rdata,
  output logic                 d_err,
  output logic                 mem_we,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0] mem_data,
  output logic [1:0]           mem_size,
  output logic                 mem_sign,
  input  logic [BUS_WIDTH-1:0] mem_out,
  input  logic                 mem_error
);
  typedef enum logic [1:0] {IDLE = 2'b00, ACCESS = 2'b01, RESP = 2'b10} state_t;
  state_t               r_state;
  logic                 r_pri_i, r_own_i, r_we, r_sign, r_err;
  logic [1:0]           r_size;
  logic [BUS_WIDTH-1:0] r_addr, r_wdata;
  logic                 w_grant_i, w_resp;
  // r_pri_i names the side that wins when both request in the same IDLE cycle
  assign w_grant_i = i_req && (!d_req || r_pri_i);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pri_i <= I_FIRST;
      r_own_i <= 1'b0;
      r_we    <= 1'b0;
      r_sign  <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_req || d_req) begin
          r_own_i <= w_grant_i;
          r_pri_i <= !w_grant_i;
          r_addr  <= w_grant_i ? i_addr : d_addr;
          r_wdata <= w_grant_i ? '0 : d_wdata;
          r_we    <= !w_grant_i && d_we;
          r_size  <= w_grant_i ? 2'b10 : d_size;
          r_sign  <= w_grant_i || d_sign;
          r_state <= ACCESS;
        end
        ACCESS: begin
          r_err   <= mem_error;
          r_state <= RESP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign w_resp   = r_state == RESP;
  assign mem_addr = r_addr;
  assign mem_data = r_wdata;
  assign mem_size = r_size;
  assign mem_sign = r_sign;
  // a faulting access never reaches the array as a write
  assign mem_we   = r_state == ACCESS && r_we && !mem_error;
  assign i_ack    = w_resp && r_own_i;
  assign d_ack    = w_resp && !r_own_i;
  assign i_rdata  = i_ack ? mem_out : '0;
  assign d_rdata  = d_ack && !r_we ? mem_out : '0;
  assign i_err    = i_ack && r_err;
  assign d_err    = d_ack && r_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// byte-array memory model and a transaction-level arbitration model.
module tb_mem_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_sign = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_out = '0;
  logic [1:0] d_size = 2'b00;
  logic i_ack, i_err, d_ack, d_err, mem_we, mem_sign, mem_error;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_data;
  logic [1:0] mem_size;
  int n_chk = 0, n_pass = 0;
  logic [7:0] mem [0:8191];
  logic [7:0] sh [0:8191];

  always #5 clk = ~clk;

  mem_arbiter #(.BUS_WIDTH(32), .I_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_sign(d_sign), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_size(mem_size),
    .mem_sign(mem_sign), .mem_out(mem_out), .mem_error(mem_error)
  );

  function automatic logic [31:0] rd(input bit from_sh, input logic [31:0] a, input logic [1:0] sz, input logic sg);
    logic [31:0] w;
    logic [12:0] ix;
    for (int k = 0; k < 4; k++) begin
      ix = a[12:0] + 13'(k);
      w[8*k +: 8] = from_sh ? sh[ix] : mem[ix];
    end
    if (sz == 2'b00) return sg ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]};
    if (sz == 2'b01) return sg ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
    return w;
  endfunction

  function automatic void wr(input bit to_sh, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [12:0] ix;
    for (int k = 0; k < 4; k++)
      if (k == 0 || (k == 1 && sz != 2'b00) || sz[1]) begin
        ix = a[12:0] + 13'(k);
        if (to_sh) sh[ix] = d[8*k +: 8];
        else mem[ix] = d[8*k +: 8];
      end
  endfunction

  function automatic logic merr(input logic [31:0] a, input logic [1:0] sz);
    return a >= 32'h2000 || (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
  endfunction

  // 8 KiB memory: combinational error, synchronous read, byte-enabled write
  assign mem_error = merr(mem_addr, mem_size);
  always @(posedge clk) begin
    mem_out <= rd(1'b0, mem_addr, mem_size, mem_sign);
    if (mem_we) wr(1'b0, mem_addr, mem_size, mem_data);
  end

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_txn(input bit p, input logic we, input logic [31:0] a, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd, output logic [31:0] r, output logic e,
                         output int lat, output int wes, output bit oth);
    r = '0; e = 1'b0; lat = -1; wes = 0; oth = 1'b0;
    if (p) begin d_req = 1'b1; d_we = we; d_addr = a; d_size = sz; d_sign = sg; d_wdata = wd; end
    else begin i_req = 1'b1; i_addr = a; end
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      @(negedge clk);
      wes += int'(mem_we);
      if (p ? i_ack : d_ack) oth = 1'b1;
      if (p ? d_ack : i_ack) begin
        lat = c;
        r = p ? d_rdata : i_rdata;
        e = p ? d_err : i_err;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    n_chk++; if (lat < 0) $display("FAIL txn_timeout: no ack within 10 cycles, port %0d addr %h", p, a); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++; if ({i_ack, d_ack, i_err, d_err, mem_we, mem_sign, mem_size} !== 7'b0)
      $display("FAIL reset_ctrl: got %b, want 0", {i_ack, d_ack, i_err, d_err, mem_we, mem_sign, mem_size}); else n_pass++;
    n_chk++; if ({mem_addr, mem_data, i_rdata, d_rdata} !== 128'b0)
      $display("FAIL reset_data: got %h, want 0", {mem_addr, mem_data, i_rdata, d_rdata}); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_fetch();
    logic [31:0] r; logic e; int lat, wes; bit oth;
    wr(1'b0, 32'h10, 2'b10, 32'hDEADBEEF);
    wr(1'b1, 32'h10, 2'b10, 32'hDEADBEEF);
    run_txn(1'b0, 1'b0, 32'h10, 2'b10, 1'b1, '0, r, e, lat, wes, oth);
    n_chk++; if (lat !== 2) $display("FAIL fetch_latency: got %0d, want 2", lat); else n_pass++;
    n_chk++; if (r !== 32'hDEADBEEF) $display("FAIL fetch_rdata: got %h, want deadbeef", r); else n_pass++;
    n_chk++; if (e !== 1'b0) $display("FAIL fetch_err: got %b, want 0", e); else n_pass++;
    n_chk++; if (oth !== 1'b0) $display("FAIL fetch_no_d_ack: got %b, want 0", oth); else n_pass++;
  endtask

  task automatic test_store_load();
    logic [31:0] r; logic e; int lat, wes; bit oth;
    run_txn(1'b1, 1'b1, 32'h22, 2'b01, 1'b0, 32'h0000ABCD, r, e, lat, wes, oth);
    n_chk++; if (wes !== 1) $display("FAIL store_we_cycles: got %0d, want 1", wes); else n_pass++;
    n_chk++; if ({e, r} !== 33'b0) $display("FAIL store_resp: got err %b rdata %h, want 0/0", e, r); else n_pass++;
    n_chk++; if (lat !== 2) $display("FAIL store_latency: got %0d, want 2", lat); else n_pass++;
    wr(1'b1, 32'h22, 2'b01, 32'h0000ABCD);
    run_txn(1'b1, 1'b0, 32'h22, 2'b01, 1'b0, '0, r, e, lat, wes, oth);
    n_chk++; if (r !== 32'hFFFFABCD) $display("FAIL load_half_signed: got %h, want ffffabcd", r); else n_pass++;
    n_chk++; if (wes !== 0 || e !== 1'b0) $display("FAIL load_side: got we %0d err %b, want 0/0", wes, e); else n_pass++;
  endtask

  task automatic test_misaligned_store();
    logic [31:0] r, old; logic e; int lat, wes; bit oth;
    old = rd(1'b1, 32'h20, 2'b10, 1'b1);
    run_txn(1'b1, 1'b1, 32'h21, 2'b10, 1'b0, ~old, r, e, lat, wes, oth);
    n_chk++; if (wes !== 0) $display("FAIL misaligned_we: got %0d, want 0", wes); else n_pass++;
    n_chk++; if (e !== 1'b1 || lat !== 2) $display("FAIL misaligned_err: got err %b lat %0d, want 1/2", e, lat); else n_pass++;
    run_txn(1'b0, 1'b0, 32'h20, 2'b10, 1'b1, '0, r, e, lat, wes, oth);
    n_chk++; if (r !== old) $display("FAIL misaligned_unchanged: got %h, want %h", r, old); else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] r; logic e; int lat, wes; bit oth;
    run_txn(1'b0, 1'b0, 32'h4000, 2'b10, 1'b1, '0, r, e, lat, wes, oth);
    n_chk++; if (e !== 1'b1 || lat !== 2) $display("FAIL oor_fetch: got err %b lat %0d, want 1/2", e, lat); else n_pass++;
  endtask

  task automatic test_contention();
    int ac [4]; bit ow [4]; int n;
    logic [31:0] got, want;
    n = 0;
    pulse_reset();
    i_addr = 32'h108; d_we = 1'b0; d_addr = 32'h104; d_size = 2'b10; d_sign = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        if (n < 4) begin ac[n] = c; ow[n] = d_ack; end
        n++;
        got = i_ack ? i_rdata : d_rdata;
        want = i_ack ? rd(1'b1, 32'h108, 2'b10, 1'b1) : rd(1'b1, 32'h104, 2'b10, 1'b0);
        n_chk++; if (got !== want) $display("FAIL contention_rdata: got %h, want %h", got, want); else n_pass++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    n_chk++; if (n !== 4) $display("FAIL contention_acks: got %0d, want 4", n); else n_pass++;
    for (int k = 0; k < 4 && k < n; k++) begin
      n_chk++; if (ac[k] !== 2 + 3*k || ow[k] !== k[0])
        $display("FAIL contention_order[%0d]: got cycle %0d owner_d %b, want %0d/%b", k, ac[k], ow[k], 2 + 3*k, k[0]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] old, ri; int first; bit bad, dseen;
    old = rd(1'b1, 32'h30, 2'b10, 1'b1);
    d_we = 1'b1; d_addr = 32'h30; d_size = 2'b10; d_sign = 1'b0; d_wdata = ~old; d_req = 1'b1;
    @(posedge clk);
    #2;
    n_chk++; if (mem_we !== 1'b1) $display("FAIL midop_access_we: got %b, want 1", mem_we); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if (mem_we !== 1'b0) $display("FAIL midop_we_drop: got %b, want 0", mem_we); else n_pass++;
    bad = 1'b0;
    repeat (3) begin @(negedge clk); if (d_ack) bad = 1'b1; end
    n_chk++; if (bad !== 1'b0) $display("FAIL midop_no_ack: got %b, want 0", bad); else n_pass++;
    d_req = 1'b0; d_we = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    i_addr = 32'h30; d_addr = 32'h40; i_req = 1'b1; d_req = 1'b1;
    first = -1; ri = '0; dseen = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (i_ack) begin if (first < 0) first = 0; ri = i_rdata; i_req = 1'b0; end
      if (d_ack) begin if (first < 0) first = 1; dseen = 1'b1; d_req = 1'b0; end
    end
    n_chk++; if (first !== 0 || !dseen) $display("FAIL midop_first_grant: got owner %0d d_seen %b, want 0/1", first, dseen); else n_pass++;
    n_chk++; if (ri !== old) $display("FAIL midop_store_aborted: got %h, want %h", ri, old); else n_pass++;
  endtask

  task automatic new_i();
    logic [31:0] a;
    a = 32'h100 + 32'($urandom_range(0, 15)) * 4;
    if ($urandom_range(0, 7) == 0) a += 32'h2000;
    else if ($urandom_range(0, 7) == 0) a += 2;
    i_addr = a;
  endtask

  task automatic new_d();
    logic [31:0] a;
    d_we = 1'($urandom); d_size = 2'($urandom_range(0, 2)); d_sign = 1'($urandom); d_wdata = $urandom;
    a = 32'h100 + 32'($urandom_range(0, 63));
    if ($urandom_range(0, 3) != 0) a = a & ~((32'h1 << d_size) - 1);
    if ($urandom_range(0, 9) == 0) a += 32'h2000;
    d_addr = a;
  endtask

  // transaction-level model: a grant is decided at the first idle sample with a
  // request pending, its ack shows two cycles later, the arbiter is free one after
  task automatic test_random();
    int t, gi, gd;
    bit own_d, pri_i, e;
    logic q_we, q_sg; logic [1:0] q_sz; logic [31:0] q_a, q_wd, exp_r, got_r;
    i_req = 1'b0; d_req = 1'b0;
    pulse_reset();
    t = -1; gi = 0; gd = 0; pri_i = 1'b1; own_d = 1'b0;
    q_we = 1'b0; q_sg = 1'b0; q_sz = 2'b00; q_a = '0; q_wd = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (t >= 0) t++;
      n_chk++; if ({i_ack, d_ack} !== {t == 2 && !own_d, t == 2 && own_d})
        $display("FAIL rnd_ack@%0d: got %b, want %b", cyc, {i_ack, d_ack}, {t == 2 && !own_d, t == 2 && own_d}); else n_pass++;
      if (t == 1) begin
        n_chk++; if ({mem_we, mem_addr, mem_size, mem_sign} !== {q_we && !merr(q_a, q_sz), q_a, q_sz, q_sg})
          $display("FAIL rnd_mem_side@%0d: got %h, want %h", cyc, {mem_we, mem_addr, mem_size, mem_sign}, {q_we && !merr(q_a, q_sz), q_a, q_sz, q_sg}); else n_pass++;
      end
      if (t == 2) begin
        e = merr(q_a, q_sz);
        n_chk++; if ((own_d ? d_err : i_err) !== e) $display("FAIL rnd_err@%0d: got %b, want %b", cyc, own_d ? d_err : i_err, e); else n_pass++;
        if (!e || q_we) begin
          exp_r = q_we ? '0 : rd(1'b1, q_a, q_sz, q_sg);
          got_r = own_d ? d_rdata : i_rdata;
          n_chk++; if (got_r !== exp_r) $display("FAIL rnd_rdata@%0d: got %h, want %h (addr %h)", cyc, got_r, exp_r, q_a); else n_pass++;
        end
        if (q_we && !e) wr(1'b1, q_a, q_sz, q_wd);
        if (own_d) begin gd = $urandom_range(0, 2); if (gd == 0) new_d(); else d_req = 1'b0; end
        else begin gi = $urandom_range(0, 2); if (gi == 0) new_i(); else i_req = 1'b0; end
      end else begin
        n_chk++; if ({i_rdata, d_rdata, i_err, d_err} !== 66'b0)
          $display("FAIL rnd_quiet@%0d: got %h, want 0", cyc, {i_rdata, d_rdata, i_err, d_err}); else n_pass++;
      end
      if (t == 3) t = -1;
      if (!i_req) begin if (gi == 0) begin new_i(); i_req = 1'b1; end else gi--; end
      if (!d_req) begin if (gd == 0) begin new_d(); d_req = 1'b1; end else gd--; end
      if (t == -1 && (i_req || d_req)) begin
        own_d = (i_req && d_req) ? !pri_i : d_req;
        pri_i = own_d;
        if (own_d) begin q_we = d_we; q_a = d_addr; q_sz = d_size; q_sg = d_sign; q_wd = d_wdata; end
        else begin q_we = 1'b0; q_a = i_addr; q_sz = 2'b10; q_sg = 1'b1; q_wd = '0; end
        t = 0;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 8192; k++) begin mem[k] = 8'($urandom); sh[k] = mem[k]; end
    test_reset();
    test_single_fetch();
    test_store_load();
    test_misaligned_store();
    test_out_of_range();
    test_contention();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
